// File: rtl/tt_um_seg7_monitor.sv
// rtl/tt_um_seg7_monitor.sv - seven-segment receive monitor: debounce, decode, count-sequence check
module tt_um_seg7_monitor #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena
);

   localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

   logic [7:0]  sync1;
   logic [7:0]  sync2;
   logic [6:0]  prev;
   logic [15:0] stab_cnt;
   logic [6:0]  acc_pat;

   logic [3:0]  digit;
   logic        locked;
   logic        bad_pattern;
   logic        step;
   logic        err_sticky;
   logic [7:0]  err_cnt;

   logic        accept;
   logic        clear;
   logic        dec_valid;
   logic [3:0]  dec_digit;
   logic [3:0]  next_digit;

   logic [3:0]  n_digit;
   logic        n_locked;
   logic        n_bad;
   logic        n_step;
   logic        n_sticky;
   logic [7:0]  n_cnt;
   logic        err_event;

   logic        unused;

   assign unused     = ^{uio_in, ena};
   assign clear      = sync2[7];
   assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

   // A pattern is taken once it has been stable long enough and differs from the last accepted one;
   // the prev check keeps a freshly changed sample from riding on the old saturated count.
   assign accept = (stab_cnt == STABLE) && (sync2[6:0] == prev) && (sync2[6:0] != acc_pat);

   // Segment pattern to BCD digit decode of the synchronized sample.
   always_comb begin
      dec_valid = 1'b1;
      dec_digit = 4'd0;
      case (sync2[6:0])
         7'h3F: dec_digit = 4'd0;
         7'h06: dec_digit = 4'd1;
         7'h5B: dec_digit = 4'd2;
         7'h4F: dec_digit = 4'd3;
         7'h66: dec_digit = 4'd4;
         7'h6D: dec_digit = 4'd5;
         7'h7C: dec_digit = 4'd6;
         7'h07: dec_digit = 4'd7;
         7'h7F: dec_digit = 4'd8;
         7'h67: dec_digit = 4'd9;
         default: dec_valid = 1'b0;
      endcase
   end

   // Classify an accepted pattern and apply clear last so it overrides any same-cycle error.
   always_comb begin
      n_digit   = digit;
      n_locked  = locked;
      n_bad     = bad_pattern;
      n_step    = 1'b0;
      err_event = 1'b0;
      if (accept) begin
         if (sync2[6:0] == 7'h00) begin
            n_locked = 1'b0;
            n_bad    = 1'b0;
         end else if (!dec_valid) begin
            n_bad     = 1'b1;
            n_locked  = 1'b0;
            err_event = 1'b1;
         end else if (!locked) begin
            n_digit  = dec_digit;
            n_locked = 1'b1;
            n_bad    = 1'b0;
         end else if (dec_digit == next_digit) begin
            n_digit = dec_digit;
            n_step  = 1'b1;
         end else begin
            n_digit   = dec_digit;
            err_event = 1'b1;
         end
      end
      n_sticky = err_sticky | err_event;
      n_cnt    = (err_event && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
      if (clear) begin
         n_locked = 1'b0;
         n_sticky = 1'b0;
         n_cnt    = 8'd0;
      end
   end

   // Synchronizer, stability counter and accepted-pattern register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 8'd0;
         sync2    <= 8'd0;
         prev     <= 7'd0;
         stab_cnt <= 16'd0;
         acc_pat  <= 7'd0;
      end else begin
         sync1 <= ui_in;
         sync2 <= sync1;
         prev  <= sync2[6:0];
         if (sync2[6:0] != prev) begin
            stab_cnt <= 16'd1;
         end else if (stab_cnt != STABLE) begin
            stab_cnt <= stab_cnt + 16'd1;
         end
         if (accept) begin
            acc_pat <= sync2[6:0];
         end
      end
   end

   // Registered monitor outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit       <= 4'd0;
         locked      <= 1'b0;
         bad_pattern <= 1'b0;
         step        <= 1'b0;
         err_sticky  <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         digit       <= n_digit;
         locked      <= n_locked;
         bad_pattern <= n_bad;
         step        <= n_step;
         err_sticky  <= n_sticky;
         err_cnt     <= n_cnt;
      end
   end

   assign uo_out  = {err_sticky, step, bad_pattern, locked, digit};
   assign uio_out = err_cnt;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_seg7_monitor.sv
// tb/tb_tt_um_seg7_monitor.sv - self-checking bench for tt_um_seg7_monitor
module tb_tt_um_seg7_monitor;

   localparam int S = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic       ena = 1'b1;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp = 0;
   int n_bad = 0;
   int step_seen = 0;

   tt_um_seg7_monitor #(.STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (seg_tab[i] == p) return i;
      end
      return -1;
   endfunction

   // Reference model: every value that reached the input pins, one entry per clock edge
   logic [7:0] hist[$];
   logic [3:0] m_dig = 4'd0;
   logic       m_lock = 1'b0;
   logic       m_bad = 1'b0;
   logic       m_step = 1'b0;
   logic       m_sticky = 1'b0;
   logic [7:0] m_cnt = 8'd0;
   logic [6:0] m_acc = 7'd0;
   bit         m_valid = 1'b0;
   int         mn;
   int         md;
   logic [6:0] mp;
   bit         mstable;
   bit         merr;

   // Model: a pattern is accepted at edge E when samples E-S-2..E-2 all agree and differ from the last one.
   always @(posedge clk) begin
      hist.push_back(rst_n ? ui_in : 8'h00);
      mn = hist.size();
      if (!rst_n) begin
         hist[mn-1] = 8'h00;
         if (mn >= 2) hist[mn-2] = 8'h00;
         m_dig = 0; m_lock = 0; m_bad = 0; m_step = 0; m_sticky = 0; m_cnt = 0; m_acc = 0;
         m_valid = 1'b1;
      end else begin
         m_step = 1'b0;
         merr = 1'b0;
         if (mn >= S + 3) begin
            mp = hist[mn-3][6:0];
            mstable = 1'b1;
            for (int k = mn - 3 - S; k < mn - 3; k++) begin
               if (hist[k][6:0] != mp) mstable = 1'b0;
            end
            if (mstable && mp != m_acc) begin
               m_acc = mp;
               md = decode(mp);
               if (mp == 7'h00) begin
                  m_lock = 0; m_bad = 0;
               end else if (md < 0) begin
                  m_bad = 1; m_lock = 0; merr = 1;
               end else if (!m_lock) begin
                  m_dig = 4'(md); m_lock = 1; m_bad = 0;
               end else if (md == (int'(m_dig) + 1) % 10) begin
                  m_dig = 4'(md); m_step = 1;
               end else begin
                  m_dig = 4'(md); merr = 1;
               end
            end
         end
         if (merr) begin
            m_sticky = 1'b1;
            if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
         end
         if (mn >= 3 && hist[mn-3][7]) begin
            m_lock = 0; m_sticky = 0; m_cnt = 0;
         end
      end
   end

   // Compare DUT against the model every cycle once a reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_uo_out", uo_out, {m_sticky, m_step, m_bad, m_lock, m_dig});
         check("cyc_uio_out", uio_out, m_cnt);
         check("cyc_uio_oe", uio_oe, 8'hFF);
         if (uo_out[6] === 1'b1) step_seen++;
      end
   end

   task automatic hold(input logic [7:0] v, input int n);
      ui_in = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      ui_in = 8'h00;
      repeat (3) @(negedge clk);
      check("t1_reset_uo", uo_out, 8'h00);
      check("t1_reset_uio", uio_out, 8'h00);

      // latency of the first lock
      rst_n = 1'b1;
      ui_in = 8'h3F;
      @(posedge clk);
      repeat (17) @(posedge clk);
      #1 check("t1_edge17", uo_out, 8'h00);
      @(posedge clk);
      #1 check("t1_edge18", uo_out, 8'h10);
      check("t1_uio", uio_out, 8'h00);
      check("t1_model", {m_sticky, m_step, m_bad, m_lock, m_dig}, 8'h10);
      @(negedge clk);

      // full count 1..9,0
      step_seen = 0;
      for (int i = 1; i < 10; i++) hold({1'b0, seg_tab[i]}, 20);
      hold(8'h3F, 20);
      check("t2_steps", 8'(step_seen), 8'd10);
      check("t2_uo", uo_out, 8'h10);
      check("t2_uio", uio_out, 8'h00);

      // glitch rejection, then a real sequence error
      hold(8'h06, 20); hold(8'h5B, 20); hold(8'h4F, 20);
      check("t3_digit3", uo_out, 8'h13);
      hold(8'h6D, 10); hold(8'h4F, 20);
      check("t3_glitch", uo_out, 8'h13);
      check("t3_glitch_uio", uio_out, 8'h00);
      hold(8'h6D, 20);
      check("t3_seqerr", uo_out, 8'h95);
      check("t3_seqerr_uio", uio_out, 8'h01);
      check("t3_model", m_cnt, 8'h01);

      // invalid pattern then blank
      hold(8'h55, 20);
      check("t4_invalid", uo_out, 8'hA5);
      check("t4_invalid_uio", uio_out, 8'h02);
      hold(8'h00, 20);
      check("t4_blank", uo_out, 8'h85);
      check("t4_blank_uio", uio_out, 8'h02);

      // saturation then clear
      hold(8'h3F, 20);
      check("t5_relock", uo_out, 8'h90);
      for (int i = 0; i < 301; i++) hold((i % 2 == 0) ? 8'h5B : 8'h3F, 20);
      check("t5_sat", uio_out, 8'hFF);
      check("t5_sat_uo", uo_out, 8'h92);
      hold(8'hDB, 3);
      hold(8'h5B, 5);
      check("t5_clear_uio", uio_out, 8'h00);
      check("t5_clear_uo", uo_out, 8'h02);

      // reset in the middle of debouncing
      hold(8'h06, 8);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_reset_uo", uo_out, 8'h00);
      check("t6_reset_uio", uio_out, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      repeat (17) @(posedge clk);
      #1 check("t6_edge17", uo_out, 8'h00);
      @(posedge clk);
      #1 check("t6_edge18", uo_out, 8'h11);
      @(negedge clk);

      // randomized traffic against the model
      for (int s = 0; s < 160; s++) begin
         logic [7:0] v;
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5)       v = {1'b0, seg_tab[(int'(m_dig) + 1) % 10]};
         else if (r < 7)  v = {1'b0, seg_tab[$urandom_range(0, 9)]};
         else if (r == 7) v = 8'h00;
         else             v = {1'b0, 7'($urandom)};
         if ($urandom_range(0, 9) == 0) v[7] = 1'b1;
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         hold(v, int'($urandom_range(1, 30)));
      end
      hold(8'h00, 25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tt_um_seg7_monitor.md
Name: tt_um_seg7_monitor

Overview:
- Receive-side companion to the counter/seven-segment display tile.
- Samples a 7-bit segment pattern on ui_in[6:0], debounces it, and decodes it back to a BCD digit.
- Checks that successive digits follow the 0..9 wrap-around count and counts sequence and pattern errors.
- Intended to be wired to the uo_out of a counting tile, or driven from the input switches for bring-up.

Parameters:
- STABLE_CYCLES, 16, number of consecutive identical synchronized samples required before a pattern is accepted. Legal range 2..65535; the counter is 16 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- ui_in  input  8  [6:0] segment pattern {g,f,e,d,c,b,a}, active-high; [7] clear request, level, active-high
- uo_out  output  8  [3:0] decoded digit; [4] locked; [5] bad_pattern; [6] step pulse; [7] error sticky
- uio_in  input  8  unused
- uio_out  output  8  error count, saturating
- uio_oe  output  8  constant 8'hFF
- ena  input  1  ignored

Behaviour:
Decode table (pattern -> digit):
- 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4
- 0x6D->5, 0x7C->6, 0x07->7, 0x7F->8, 0x67->9
- 0x00 is blank. Any other value is invalid.

Reset (rst_n low at a clk edge):
- All registers go to 0: uo_out=0x00, uio_out=0x00.
- Accepted pattern register = 0x00 (blank).
- Stability counter = 0.
- Reset mid-debounce discards the pending pattern.

Input path:
- ui_in is passed through a 2-flop synchronizer (sync1, sync2); ui_in[7] uses the same synchronizer.
- Register prev <= sync2.
- Stability counter:
  - cleared to 1 when sync2 != prev;
  - otherwise increments, saturating at STABLE_CYCLES.
- Accept event: a one-cycle strobe, asserted when the counter reaches STABLE_CYCLES and sync2 != the accepted pattern.
- End-to-end latency: a pattern held at ui_in from edge N onward updates the outputs at edge N+STABLE_CYCLES+2.
- Pulses shorter than STABLE_CYCLES samples cause no output change.
- Re-accepting the same pattern is not an event.

On an accept event, the accepted pattern register is updated and one of the following happens:
- Blank:
  - locked <= 0, bad_pattern <= 0;
  - digit holds; no error.
- Invalid:
  - bad_pattern <= 1, locked <= 0;
  - error event; digit holds.
- Valid, locked=0:
  - digit <= decoded value;
  - locked <= 1, bad_pattern <= 0;
  - no step pulse, no error.
- Valid, locked=1, decoded == (digit==9 ? 0 : digit+1):
  - digit <= decoded;
  - step (uo_out[6]) high for exactly 1 cycle.
- Valid, locked=1, any other value:
  - digit <= decoded, locked stays 1;
  - error event; no step pulse.

Error event:
- Error count increments, saturating at 255 (no wrap).
- Sticky error bit uo_out[7] <= 1.

Clear (synchronized ui_in[7]=1):
- Each cycle it is high, it clears the error count, the sticky bit and locked.
- Digit and the accepted pattern register are unaffected.
- Clear in the same cycle as an error event: clear wins, count=0.
- While clear is held, an accepted valid pattern does not set locked. Locking resumes on the first valid accept after clear is released.

All outputs are registered; there is no combinational path from ui_in to the outputs.

Test Plan:
1. Reset, then hold ui_in=0x3F; STABLE_CYCLES=16 -> uo_out=0x10 (digit 0, locked) exactly 18 edges after the first sample; uio_out=0.
2. Drive 0x3F,0x06,...,0x67, then 0x3F, each held 20 cycles -> digit 1..9 then 0; uo_out[6] pulses 10 times, 1 cycle each; uio_out stays 0.
3. While digit=3 is locked, drive a 0x6D glitch for 10 cycles, then return to 0x4F -> no output change, no error. Then hold 0x6D for 20 cycles -> digit=5, uio_out=1, uo_out[7]=1, no step pulse.
4. Drive invalid 0x55 for 20 cycles -> uo_out[5]=1, locked=0, error count +1. Then drive 0x00 -> bad_pattern=0, no error.
5. Force 300 sequence errors -> uio_out saturates at 0xFF. Pulse ui_in[7] -> uio_out=0, uo_out[7]=0, locked=0, digit unchanged.
6. Pull rst_n low for 1 cycle in the middle of debouncing 0x06 -> all outputs 0. The pattern is accepted only after a fresh 16 stable samples.
